// File: rtl/alu_control_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_control_seq
// Brief    : Registered ALU-control decoder with MULT/DIV start/stall sequencing.
//            Optional illegal-Funct trap enabled by defining ALU_CTRL_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_control_seq #(
    parameter int CTRL_W     = 4,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Valid,
    input  logic [1:0]        ALUOp,
    input  logic [5:0]        Funct,
    output logic [CTRL_W-1:0] ALUControl,
    output logic              CtrlValid,
    output logic              MDUStart,
    output logic [1:0]        MDUOp,
    output logic              Stall,
    output logic              Illegal
);

    localparam logic [3:0] c_AND = 4'b0000;
    localparam logic [3:0] c_OR  = 4'b0001;
    localparam logic [3:0] c_ADD = 4'b0010;
    localparam logic [3:0] c_XOR = 4'b0011;
    localparam logic [3:0] c_SLL = 4'b0100;
    localparam logic [3:0] c_SRL = 4'b0101;
    localparam logic [3:0] c_SUB = 4'b0110;
    localparam logic [3:0] c_SLT = 4'b0111;
    localparam logic [3:0] c_NOR = 4'b1100;
    localparam logic [3:0] c_SRA = 4'b1101;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_TRAP = 2'd2;

`ifdef ALU_CTRL_TRAP_EN
    localparam bit c_TRAP_EN = 1'b1;
`else
    localparam bit c_TRAP_EN = 1'b0;
`endif

    // Counter holds N-1 at most, so clog2 of the longest op is enough.
    localparam int c_MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W   = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_MUL_LOAD = c_CNT_W'(MUL_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD = c_CNT_W'(DIV_CYCLES - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_alu_ctrl;
    logic               r_ctrl_valid;
    logic               r_mdu_start;
    logic [1:0]         r_mdu_op;

    logic [3:0]         w_op;
    logic               w_is_mdu;
    logic               w_bad;
    logic               w_accept;
    logic               w_trap;

    // Funct is only consulted for R-type; other ALUOp codes map directly.
    always_comb begin
        w_op     = c_ADD;
        w_is_mdu = 1'b0;
        w_bad    = 1'b0;
        case (ALUOp)
            2'b00: w_op = c_ADD;
            2'b01: w_op = c_SUB;
            2'b11: w_op = c_OR;
            default: begin
                case (Funct)
                    6'b100000, 6'b100001: w_op = c_ADD;
                    6'b100010, 6'b100011: w_op = c_SUB;
                    6'b100100:            w_op = c_AND;
                    6'b100101:            w_op = c_OR;
                    6'b100110:            w_op = c_XOR;
                    6'b100111:            w_op = c_NOR;
                    6'b101010, 6'b101011: w_op = c_SLT;
                    6'b000000:            w_op = c_SLL;
                    6'b000010:            w_op = c_SRL;
                    6'b000011:            w_op = c_SRA;
                    6'b011000, 6'b011001,
                    6'b011010, 6'b011011: w_is_mdu = 1'b1;
                    default:              w_bad = 1'b1;
                endcase
            end
        endcase
    end

    assign w_accept = (r_state == c_IDLE) && Valid;
    assign w_trap   = w_bad && c_TRAP_EN;

    // State register and datapath registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state      <= c_IDLE;
            r_cnt        <= '0;
            r_alu_ctrl   <= 4'b0000;
            r_ctrl_valid <= 1'b0;
            r_mdu_start  <= 1'b0;
            r_mdu_op     <= 2'b00;
        end else begin
            r_state      <= w_state_nxt;
            r_ctrl_valid <= 1'b0;
            r_mdu_start  <= 1'b0;
            if (w_accept) begin
                if (w_is_mdu) begin
                    r_ctrl_valid <= 1'b1;
                    r_mdu_start  <= 1'b1;
                    r_mdu_op     <= Funct[1:0];
                    r_cnt        <= Funct[1] ? c_DIV_LOAD : c_MUL_LOAD;
                end else if (!w_trap) begin
                    r_ctrl_valid <= 1'b1;
                    r_alu_ctrl   <= w_op;
                end
            end else if (r_state == c_BUSY && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

`ifdef ALU_CTRL_TRAP_EN
    logic r_illegal;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_illegal <= 1'b0;
        end else if (w_accept && w_trap) begin
            r_illegal <= 1'b1;
        end
    end

    assign Illegal = r_illegal;
`else
    assign Illegal = 1'b0;
`endif

    // Next-state logic; N=1 still spends one cycle in BUSY so Stall lasts N cycles.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (Valid) begin
                    if (w_is_mdu) begin
                        w_state_nxt = c_BUSY;
                    end else if (w_trap) begin
                        w_state_nxt = c_TRAP;
                    end
                end
            end
            c_BUSY: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_TRAP:  w_state_nxt = c_TRAP;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ALUControl      = '0;
        ALUControl[3:0] = r_alu_ctrl;
        CtrlValid       = r_ctrl_valid;
        MDUStart        = r_mdu_start;
        MDUOp           = r_mdu_op;
        Stall           = (r_state == c_BUSY);
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_control_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_control_seq
// Brief    : Directed self-checking bench for alu_control_seq (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_control_seq;

    logic       Clk;
    logic       Rst;
    logic       Valid;
    logic [1:0] ALUOp;
    logic [5:0] Funct;
    logic [3:0] ALUControl;
    logic       CtrlValid;
    logic       MDUStart;
    logic [1:0] MDUOp;
    logic       Stall;
    logic       Illegal;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_alu = 4'b0000;

    alu_control_seq #(
        .CTRL_W    (4),
        .MUL_CYCLES(4),
        .DIV_CYCLES(32)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Valid     (Valid),
        .ALUOp     (ALUOp),
        .Funct     (Funct),
        .ALUControl(ALUControl),
        .CtrlValid (CtrlValid),
        .MDUStart  (MDUStart),
        .MDUOp     (MDUOp),
        .Stall     (Stall),
        .Illegal   (Illegal)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1; Valid = 1'b0; ALUOp = 2'b00; Funct = 6'b000000;
        tick(); tick();
        Rst = 1'b0;
        total++; if (ALUControl !== 4'b0000) begin bad++; $display("FAIL reset_alu got=%b exp=0000", ALUControl); end
        total++; if (CtrlValid !== 1'b0) begin bad++; $display("FAIL reset_cv got=%b exp=0", CtrlValid); end
        total++; if (MDUStart !== 1'b0) begin bad++; $display("FAIL reset_start got=%b exp=0", MDUStart); end
        total++; if (MDUOp !== 2'b00) begin bad++; $display("FAIL reset_mduop got=%b exp=00", MDUOp); end
        total++; if (Stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", Stall); end
        total++; if (Illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b exp=0", Illegal); end
        exp_alu = 4'b0000;
    endtask

    task automatic test_nor();
        Valid = 1'b1; ALUOp = 2'b10; Funct = 6'b100111;
        tick();
        Valid = 1'b0;
        total++; if (ALUControl !== 4'b1100) begin bad++; $display("FAIL nor_alu got=%b exp=1100", ALUControl); end
        total++; if (CtrlValid !== 1'b1) begin bad++; $display("FAIL nor_cv got=%b exp=1", CtrlValid); end
        total++; if (Stall !== 1'b0) begin bad++; $display("FAIL nor_stall got=%b exp=0", Stall); end
        tick();
        total++; if (CtrlValid !== 1'b0) begin bad++; $display("FAIL nor_cv_pulse got=%b exp=0", CtrlValid); end
        total++; if (ALUControl !== 4'b1100) begin bad++; $display("FAIL nor_hold got=%b exp=1100", ALUControl); end
        exp_alu = 4'b1100;
    endtask

    task automatic test_back_to_back();
        logic [1:0] ops  [3] = '{2'b00, 2'b01, 2'b11};
        logic [3:0] exps [3] = '{4'b0010, 4'b0110, 4'b0001};
        // Funct looks like MULT but must be ignored for non-R-type ALUOp
        Funct = 6'b011000;
        for (int i = 0; i < 3; i++) begin
            Valid = 1'b1; ALUOp = ops[i];
            tick();
            total++; if (ALUControl !== exps[i] || CtrlValid !== 1'b1 || Stall !== 1'b0)
                begin bad++; $display("FAIL b2b_%0d alu=%b cv=%b stall=%b exp alu=%b cv=1 stall=0", i, ALUControl, CtrlValid, Stall, exps[i]); end
        end
        Valid = 1'b0;
        tick();
        total++; if (CtrlValid !== 1'b0) begin bad++; $display("FAIL b2b_idle_cv got=%b exp=0", CtrlValid); end
        exp_alu = 4'b0001;
    endtask

    task automatic test_rtype_table();
        logic [5:0] fn [10] = '{6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b100110,
                                6'b101010, 6'b101011, 6'b000000, 6'b000010, 6'b000011};
        logic [3:0] ex [10] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0011,
                                4'b0111, 4'b0111, 4'b0100, 4'b0101, 4'b1101};
        ALUOp = 2'b10;
        for (int i = 0; i < 10; i++) begin
            Valid = 1'b1; Funct = fn[i];
            tick();
            total++; if (ALUControl !== ex[i] || CtrlValid !== 1'b1)
                begin bad++; $display("FAIL rtype_%b alu=%b cv=%b exp alu=%b cv=1", fn[i], ALUControl, CtrlValid, ex[i]); end
        end
        Valid = 1'b0;
        exp_alu = 4'b1101;
        tick();
    endtask

    task automatic test_mult();
        int n_stall;
        Valid = 1'b1; ALUOp = 2'b10; Funct = 6'b011000;
        tick();
        // Upstream misbehaves: ADD request held high throughout the stall
        Funct = 6'b100000;
        total++; if (MDUStart !== 1'b1 || MDUOp !== 2'b00 || Stall !== 1'b1 || CtrlValid !== 1'b1)
            begin bad++; $display("FAIL mult_start start=%b op=%b stall=%b cv=%b exp 1 00 1 1", MDUStart, MDUOp, Stall, CtrlValid); end
        total++; if (ALUControl !== exp_alu) begin bad++; $display("FAIL mult_alu_hold got=%b exp=%b", ALUControl, exp_alu); end
        n_stall = 1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!Stall) break;
            n_stall++;
            total++; if (MDUStart !== 1'b0 || CtrlValid !== 1'b0)
                begin bad++; $display("FAIL mult_busy_%0d start=%b cv=%b exp 0 0", n_stall, MDUStart, CtrlValid); end
        end
        total++; if (n_stall !== 4) begin bad++; $display("FAIL mult_stall_len got=%0d exp=4", n_stall); end
        total++; if (CtrlValid !== 1'b0) begin bad++; $display("FAIL mult_ignored_valid got=%b exp=0", CtrlValid); end
        tick();
        Valid = 1'b0;
        total++; if (CtrlValid !== 1'b1 || ALUControl !== 4'b0010)
            begin bad++; $display("FAIL mult_after cv=%b alu=%b exp 1 0010", CtrlValid, ALUControl); end
        total++; if (MDUOp !== 2'b00) begin bad++; $display("FAIL mult_op_hold got=%b exp=00", MDUOp); end
        exp_alu = 4'b0010;
        tick();
    endtask

    task automatic test_multu();
        int n_stall;
        Valid = 1'b1; ALUOp = 2'b10; Funct = 6'b011001;
        tick();
        Valid = 1'b0;
        total++; if (MDUStart !== 1'b1 || MDUOp !== 2'b01)
            begin bad++; $display("FAIL multu_start start=%b op=%b exp 1 01", MDUStart, MDUOp); end
        n_stall = 0;
        for (int i = 0; i < 100; i++) begin
            if (!Stall) break;
            n_stall++;
            tick();
        end
        total++; if (n_stall !== 4) begin bad++; $display("FAIL multu_stall_len got=%0d exp=4", n_stall); end
    endtask

    task automatic test_div_reset();
        int stray;
        Valid = 1'b1; ALUOp = 2'b10; Funct = 6'b011010;
        tick();
        Valid = 1'b0;
        total++; if (MDUStart !== 1'b1 || MDUOp !== 2'b10 || Stall !== 1'b1)
            begin bad++; $display("FAIL div_start start=%b op=%b stall=%b exp 1 10 1", MDUStart, MDUOp, Stall); end
        for (int i = 2; i <= 10; i++) tick();
        total++; if (Stall !== 1'b1) begin bad++; $display("FAIL div_stall10 got=%b exp=1", Stall); end
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        total++; if (Stall !== 1'b0 || ALUControl !== 4'b0000 || CtrlValid !== 1'b0 ||
                     MDUStart !== 1'b0 || MDUOp !== 2'b00 || Illegal !== 1'b0)
            begin bad++; $display("FAIL div_abort stall=%b alu=%b cv=%b start=%b op=%b ill=%b exp all 0",
                                  Stall, ALUControl, CtrlValid, MDUStart, MDUOp, Illegal); end
        exp_alu = 4'b0000;
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (MDUStart !== 1'b0 || Stall !== 1'b0) stray++;
        end
        total++; if (stray !== 0) begin bad++; $display("FAIL div_no_restart got=%0d exp=0", stray); end
        Valid = 1'b1; Funct = 6'b100010;
        tick();
        Valid = 1'b0;
        total++; if (CtrlValid !== 1'b1 || ALUControl !== 4'b0110)
            begin bad++; $display("FAIL div_after cv=%b alu=%b exp 1 0110", CtrlValid, ALUControl); end
        exp_alu = 4'b0110;
    endtask

    task automatic test_reset_priority();
        Valid = 1'b1; ALUOp = 2'b00; Rst = 1'b1;
        tick();
        Rst = 1'b0; Valid = 1'b0;
        total++; if (CtrlValid !== 1'b0 || ALUControl !== 4'b0000)
            begin bad++; $display("FAIL rstprio cv=%b alu=%b exp 0 0000", CtrlValid, ALUControl); end
        tick();
        total++; if (CtrlValid !== 1'b0) begin bad++; $display("FAIL rstprio_dropped got=%b exp=0", CtrlValid); end
        exp_alu = 4'b0000;
    endtask

    task automatic test_illegal();
        Valid = 1'b1; ALUOp = 2'b10; Funct = 6'b111111;
        tick();
        Valid = 1'b0;
`ifdef ALU_CTRL_TRAP_EN
        total++; if (Illegal !== 1'b1 || CtrlValid !== 1'b0 || ALUControl !== exp_alu)
            begin bad++; $display("FAIL trap_enter ill=%b cv=%b alu=%b exp 1 0 %b", Illegal, CtrlValid, ALUControl, exp_alu); end
        Valid = 1'b1; Funct = 6'b100000;
        tick(); tick();
        Valid = 1'b0;
        total++; if (Illegal !== 1'b1 || CtrlValid !== 1'b0)
            begin bad++; $display("FAIL trap_sticky ill=%b cv=%b exp 1 0", Illegal, CtrlValid); end
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        total++; if (Illegal !== 1'b0) begin bad++; $display("FAIL trap_clear got=%b exp=0", Illegal); end
        Valid = 1'b1;
        tick();
        Valid = 1'b0;
        total++; if (CtrlValid !== 1'b1 || ALUControl !== 4'b0010)
            begin bad++; $display("FAIL trap_after cv=%b alu=%b exp 1 0010", CtrlValid, ALUControl); end
`else
        total++; if (ALUControl !== 4'b0010 || CtrlValid !== 1'b1 || Illegal !== 1'b0)
            begin bad++; $display("FAIL illegal_as_add alu=%b cv=%b ill=%b exp 0010 1 0", ALUControl, CtrlValid, Illegal); end
        tick();
        total++; if (Illegal !== 1'b0 || Stall !== 1'b0)
            begin bad++; $display("FAIL illegal_quiet ill=%b stall=%b exp 0 0", Illegal, Stall); end
`endif
        exp_alu = 4'b0010;
    endtask

    initial begin
        Rst = 1'b1; Valid = 1'b0; ALUOp = 2'b00; Funct = 6'b000000;
        test_reset();
        test_nor();
        test_back_to_back();
        test_rtype_table();
        test_mult();
        test_multu();
        test_div_reset();
        test_reset_priority();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
